// File: rtl/cmult_arb.sv
// cmult_arb: round-robin scheduler sharing one external pipelined complex
// multiplier among N_REQ requesters. One operand pair is accepted per cycle,
// registered onto the multiplier inputs, and tagged with its requester id.
// The tag rides a shift register matched to the multiplier latency so the
// product can be steered back to its owner as a one-cycle r_valid strobe.
module cmult_arb #(
  parameter int N_REQ = 4,  // number of requesters (2..8)
  parameter int LAT   = 4   // multiplier latency, registered inputs to dout
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [N_REQ-1:0]      s_valid,
  output logic [N_REQ-1:0]      s_ready,
  input  logic [16*N_REQ-1:0]   s_a_i,
  input  logic [16*N_REQ-1:0]   s_a_q,
  input  logic [16*N_REQ-1:0]   s_b_i,
  input  logic [16*N_REQ-1:0]   s_b_q,
  output logic [15:0]           m_din_i0,
  output logic [15:0]           m_din_q0,
  output logic [15:0]           m_din_i1,
  output logic [15:0]           m_din_q1,
  input  logic [31:0]           m_dout_i,
  input  logic [31:0]           m_dout_q,
  output logic [N_REQ-1:0]      r_valid,
  output logic [31:0]           r_dout_i,
  output logic [31:0]           r_dout_q,
  output logic                  busy
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [ID_W-1:0] id_t;
  typedef logic [ID_W:0]   sum_t;

  // One tag per in-flight operation: who issued it and whether it is real.
  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  id_t  ptr;
  id_t  ptr_nxt;
  id_t  grant_id;
  logic grant;
  sum_t sum;
  tag_t tags [LAT+1];

  // Round-robin search from ptr upward with wrap; first valid requester wins.
  // NOTE: every output of a combinational block is given a default before any
  // branch, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    sum      = '0;
    if (en && rstn) begin
      for (int i = 0; i < N_REQ; i++) begin
        sum = {1'b0, ptr} + sum_t'(i);
        if (sum >= sum_t'(N_REQ)) begin
          sum = sum - sum_t'(N_REQ);
        end
        if (!grant && s_valid[sum[ID_W-1:0]]) begin
          grant    = 1'b1;
          grant_id = sum[ID_W-1:0];
        end
      end
    end
  end

  // One-hot ready for the winner; the pointer moves just past the winner.
  always_comb begin
    s_ready = '0;
    ptr_nxt = ptr;
    if (grant) begin
      s_ready = N_REQ'(1) << grant_id;
      ptr_nxt = (grant_id == id_t'(N_REQ - 1)) ? '0 : grant_id + id_t'(1);
    end
  end

  // Round-robin pointer register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // Operand registers feeding the multiplier; they hold when nothing is granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_din_i0 <= '0;
      m_din_q0 <= '0;
      m_din_i1 <= '0;
      m_din_q1 <= '0;
    end else if (grant) begin
      m_din_i0 <= s_a_i[16*grant_id +: 16];
      m_din_q0 <= s_a_q[16*grant_id +: 16];
      m_din_i1 <= s_b_i[16*grant_id +: 16];
      m_din_q1 <= s_b_q[16*grant_id +: 16];
    end
  end

  // Tag shift register, LAT+1 deep, advancing every cycle.
  // NOTE: this array is reset because a stale valid bit would emit a phantom
  // result; it is a handful of flops, not a RAM, so the reset is cheap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{vld: grant, id: grant_id};
      for (int i = 1; i <= LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Result register: strobe the owner and capture the product when the last
  // tag stage is valid; data holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid  <= '0;
      r_dout_i <= '0;
      r_dout_q <= '0;
    end else begin
      r_valid <= '0;
      if (tags[LAT].vld) begin
        r_valid  <= N_REQ'(1) << tags[LAT].id;
        r_dout_i <= m_dout_i;
        r_dout_q <= m_dout_q;
      end
    end
  end

  // Busy while anything is tagged in flight or a result strobe is out.
  always_comb begin
    busy = |r_valid;
    for (int i = 0; i <= LAT; i++) begin
      busy = busy | tags[i].vld;
    end
  end

endmodule
